pmt_pulse_emulator: RTL and testbench
=====================================

Name: pmt_pulse_emulator

Overview:
Synthetic photomultiplier source that drives the photon-counter's PMT pulse input on the bench or on a spare GPIO loopback.
- Watches the light-modulation output.
- Emits pulses at separately programmable per-cycle probabilities for the lit and dark phases, using an LFSR.
- Enforces a fixed pulse width and dead time.
- Keeps ground-truth lit/dark pulse counts, so the add/subtract counts on the counting side can be checked against a known source.

Parameters:
PULSE_WIDTH, 5, cycles pulse_out_pin is held high per pulse (>=1)
DEAD_TIME, 10, low cycles enforced after each pulse (>=1)
SEED, 32'h1, LFSR reset value; 0 is replaced by 1

Ports:
clock_50_mhz  in  1  system clock
reset  in  1  asynchronous active-high reset
enable  in  1  allow new pulses to start
light_source_in  in  1  light-modulation level; asynchronous, synchronised internally
lit_threshold  in  32  per-cycle fire probability while lit (value/2^32); 32'hFFFFFFFF = always fire
dark_threshold  in  32  per-cycle fire probability while dark; same encoding
count_clear  in  1  synchronous clear of both truth counters
pulse_out_pin  out  1  emulated PMT pulse, registered
lit_pulse_count  out  32  pulses started while lit, saturating
dark_pulse_count  out  32  pulses started while dark, saturating
busy  out  1  high in PULSE or DEAD

Behaviour:
Reset (async, immediate):
- State=IDLE; all outputs 0; LFSR=SEED (or 1 if SEED=0); both synchroniser flops 0.
- A reset asserted mid-pulse drops pulse_out_pin the same instant.

Light synchroniser:
- Two-flop synchroniser on light_source_in.
- The synchronised level (light_s) lags the input by 2 cycles.

LFSR:
- 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
- Advances every cycle in every state, independent of enable.
- Never holds 0.

Fire condition, evaluated only in IDLE:
- thr = light_s ? lit_threshold : dark_threshold.
- fire = enable && (thr == 32'hFFFFFFFF || lfsr < thr).
- thr == 0 never fires.

State machine:
- IDLE: on fire -> PULSE. pulse_out_pin=1 from the next cycle; internal counter loaded with PULSE_WIDTH-1. The light_s value at the fire cycle is latched as the pulse's tag.
- PULSE: pulse_out_pin=1. On counter=0 -> DEAD with counter=DEAD_TIME-1, and pulse_out_pin=0 from the next cycle. Otherwise decrement.
- DEAD: pulse_out_pin=0. On counter=0 -> IDLE. Otherwise decrement.

Timing:
- pulse_out_pin rises 1 cycle after the fire cycle.
- Width is exactly PULSE_WIDTH cycles.
- Minimum rising-edge-to-rising-edge spacing is PULSE_WIDTH+DEAD_TIME+1 cycles (16 at defaults).

Enable:
- Deasserting enable in PULSE or DEAD does not truncate; the pulse and dead time complete.
- With enable low, the block then stays in IDLE.

Light changes:
- A light change during PULSE/DEAD does not alter the tag of the pulse in flight.

Truth counters:
- Update in the fire cycle: the tagged-lit pulse increments lit_pulse_count, otherwise dark_pulse_count.
- Both saturate at 32'hFFFFFFFF.
- count_clear zeroes both; clear wins over a same-cycle increment.
- count_clear does not affect the state machine or the LFSR.

busy: registered; equals (state != IDLE) with the same timing as pulse_out_pin entry/exit.

Width rules:
- Internal duration counter is 32-bit unsigned; the larger of PULSE_WIDTH and DEAD_TIME must fit.
- No signed arithmetic.

Test Plan:
1. Reset, enable=1, light_source_in=1, lit_threshold=FFFFFFFF, run 160 cycles after light_s settles -> exactly 10 rising edges spaced 16 cycles, each high exactly 5 cycles; lit_pulse_count=10, dark_pulse_count=0.
2. enable=1, both thresholds=0, toggle light every 100 cycles for 10000 cycles -> pulse_out_pin constant 0, busy 0, both counts 0.
3. lit_threshold=FFFFFFFF, dark_threshold=0, light toggles every 50 cycles for 1000 cycles -> pulses only while light_s=1; dark_pulse_count=0; lit_pulse_count equals counted rising edges; light fall mid-pulse does not shorten it.
4. Always-fire, deassert enable on the 2nd cycle of a pulse -> pulse still 5 high cycles, then 10 low, busy falls, no further pulses.
5. Assert reset during PULSE -> pulse_out_pin and busy 0 immediately; after release, LFSR sequence restarts from SEED, matching a reference model cycle-for-cycle; counts 0.
6. Force lit_pulse_count near FFFFFFFE via long always-fire run (or fast-forward model check), assert count_clear in the same cycle as a fire -> count reads 0 next cycle; separately confirm saturation holds at FFFFFFFF.

Source files
------------

// File: rtl/pmt_pulse_emulator.sv
// Synthetic PMT pulse source: LFSR-driven random pulses with separate lit/dark
// fire probabilities, fixed width and dead time, and ground-truth pulse counters.
module pmt_pulse_emulator #(
    parameter int unsigned PULSE_WIDTH = 5,
    parameter int unsigned DEAD_TIME   = 10,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic        clock_50_mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic        light_source_in,
    input  logic [31:0] lit_threshold,
    input  logic [31:0] dark_threshold,
    input  logic        count_clear,
    output logic        pulse_out_pin,
    output logic [31:0] lit_pulse_count,
    output logic [31:0] dark_pulse_count,
    output logic        busy
);

    // state    | meaning
    // ST_IDLE  | waiting for a fire decision (only state that evaluates fire)
    // ST_PULSE | pulse_out_pin high, counting down the pulse width
    // ST_DEAD  | pulse_out_pin low, counting down the dead time
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] PW_LOAD   = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0] DT_LOAD   = 32'(DEAD_TIME - 1);
    localparam logic [31:0] ALL_ONES  = 32'hFFFFFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;

    logic        r_sync1;
    logic        r_light_s;

    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_nxt;

    logic [31:0] w_thr;
    logic        w_fire;

    logic        r_pulse;
    logic        r_busy;
    logic [31:0] r_lit_count;
    logic [31:0] r_dark_count;

    always_ff @(posedge clock_50_mhz or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_light_s <= 1'b0;
        end else begin
            r_sync1   <= light_source_in;
            r_light_s <= r_sync1;
        end
    end

    // Right-shifting Galois form; a nonzero seed can never reach zero.
    always_comb begin
        w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
    end

    always_ff @(posedge clock_50_mhz or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_INIT;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    // All-ones is treated as certainty since lfsr < thr alone would miss one value.
    always_comb begin
        w_thr  = r_light_s ? lit_threshold : dark_threshold;
        w_fire = (r_state == ST_IDLE) && enable &&
                 ((w_thr == ALL_ONES) || (r_lfsr < w_thr));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = PW_LOAD;
                end
            end
            ST_PULSE: begin
                if (r_cnt == 32'h0) begin
                    w_state_nxt = ST_DEAD;
                    w_cnt_nxt   = DT_LOAD;
                end else begin
                    w_cnt_nxt   = r_cnt - 32'h1;
                end
            end
            ST_DEAD: begin
                if (r_cnt == 32'h0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 32'h1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 32'h0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state entry.
    always_ff @(posedge clock_50_mhz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'h0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= (w_state_nxt == ST_PULSE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // The light level sampled in the fire cycle is the pulse's tag.
    always_ff @(posedge clock_50_mhz or posedge reset) begin
        if (reset) begin
            r_lit_count  <= 32'h0;
            r_dark_count <= 32'h0;
        end else if (count_clear) begin
            r_lit_count  <= 32'h0;
            r_dark_count <= 32'h0;
        end else if (w_fire) begin
            if (r_light_s) begin
                if (r_lit_count != ALL_ONES) begin
                    r_lit_count <= r_lit_count + 32'h1;
                end
            end else begin
                if (r_dark_count != ALL_ONES) begin
                    r_dark_count <= r_dark_count + 32'h1;
                end
            end
        end
    end

    assign pulse_out_pin    = r_pulse;
    assign busy             = r_busy;
    assign lit_pulse_count  = r_lit_count;
    assign dark_pulse_count = r_dark_count;

endmodule

// File: tb/tb_pmt_pulse_emulator.sv
// Directed bench for pmt_pulse_emulator: timing, gating, tagging, reset,
// LFSR sequence, counter clear and saturation.
module tb_pmt_pulse_emulator;

    logic        clk;
    logic        rst;
    logic        en;
    logic        light;
    logic [31:0] lit_thr;
    logic [31:0] dark_thr;
    logic        clr;
    logic        pulse;
    logic [31:0] lit_cnt;
    logic [31:0] dark_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    pmt_pulse_emulator #(
        .PULSE_WIDTH(5),
        .DEAD_TIME  (10),
        .SEED       (32'h1)
    ) dut (
        .clock_50_mhz    (clk),
        .reset           (rst),
        .enable          (en),
        .light_source_in (light),
        .lit_threshold   (lit_thr),
        .dark_threshold  (dark_thr),
        .count_clear     (clr),
        .pulse_out_pin   (pulse),
        .lit_pulse_count (lit_cnt),
        .dark_pulse_count(dark_cnt),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference LFSR, reset alongside the DUT.
    logic [31:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 32'h1;
        else     m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the bench just after a negedge with reset released (sample 0).
    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_lit",   lit_cnt,    32'h0);
        chk("rst_dark",  dark_cnt,   32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int rises;
        int hi;
        logic prev;
        logic seen_p;
        logic seen_b;

        rst = 1'b1; en = 1'b0; light = 1'b0; lit_thr = 32'h0; dark_thr = 32'h0; clr = 1'b0;

        // 1: always-fire while lit, periodic 16-cycle pulse train
        en = 1'b1; light = 1'b1; lit_thr = 32'hFFFFFFFF; dark_thr = 32'h0;
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            tick();
            chk("t1_pulse", 32'(pulse), 32'((k >= 3) && (((k - 3) % 16) < 5)));
            chk("t1_busy",  32'(busy),  32'((k >= 3) && (((k - 3) % 16) < 15)));
        end
        chk("t1_lit",  lit_cnt,  32'd10);
        chk("t1_dark", dark_cnt, 32'd0);

        // 2: zero thresholds never fire
        lit_thr = 32'h0; dark_thr = 32'h0; light = 1'b0;
        do_reset();
        seen_p = 1'b0; seen_b = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            if (pulse) seen_p = 1'b1;
            if (busy)  seen_b = 1'b1;
            if ((k % 100) == 0) light = ~light;
        end
        chk("t2_pulse", 32'(seen_p), 32'h0);
        chk("t2_busy",  32'(seen_b), 32'h0);
        chk("t2_lit",   lit_cnt,     32'h0);
        chk("t2_dark",  dark_cnt,    32'h0);

        // 3: lit-only firing with light toggling; 4 pulses per lit window
        lit_thr = 32'hFFFFFFFF; dark_thr = 32'h0; light = 1'b1;
        do_reset();
        rises = 0; hi = 0; prev = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (pulse && !prev) rises++;
            if (pulse) hi++;
            else if (prev) begin
                chk("t3_width", 32'(hi), 32'd5);
                hi = 0;
            end
            prev = pulse;
            if ((k % 50) == 0) light = ~light;
        end
        chk("t3_rises", 32'(rises), 32'd40);
        chk("t3_lit",   lit_cnt,    32'd40);
        chk("t3_dark",  dark_cnt,   32'd0);

        // 4: dropping enable mid-pulse completes pulse and dead time
        en = 1'b1; light = 1'b1; lit_thr = 32'hFFFFFFFF; dark_thr = 32'h0;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            tick();
            chk("t4_pulse", 32'(pulse), 32'((k >= 3) && (k <= 7)));
            chk("t4_busy",  32'(busy),  32'((k >= 3) && (k <= 17)));
            if (k == 4) en = 1'b0;
        end
        chk("t4_lit", lit_cnt, 32'd1);

        // 5: async reset mid-pulse, then LFSR restarts from seed
        en = 1'b1;
        do_reset();
        for (int k = 1; k <= 5; k++) tick();
        chk("t5_pre_pulse", 32'(pulse), 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_pulse", 32'(pulse), 32'h0);
        chk("t5_rst_busy",  32'(busy),  32'h0);
        chk("t5_rst_lit",   lit_cnt,    32'h0);
        tick();
        rst = 1'b0;
        chk("t5_seed", dut.r_lfsr, 32'h00000001);
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 1) chk("t5_lfsr1", dut.r_lfsr, 32'h80200003);
            if (k == 2) chk("t5_lfsr2", dut.r_lfsr, 32'hC0300002);
            if (k == 3) chk("t5_lfsr3", dut.r_lfsr, 32'h60180001);
            chk("t5_lfsr", dut.r_lfsr, m_lfsr);
        end

        // 6: clear beats a same-cycle fire; saturation at all-ones
        en = 1'b1; light = 1'b1; lit_thr = 32'hFFFFFFFF; dark_thr = 32'h0;
        do_reset();
        tick(); tick();
        clr = 1'b1;
        tick();
        chk("t6_clr_lit",   lit_cnt,    32'h0);
        chk("t6_clr_pulse", 32'(pulse), 32'h1);
        clr = 1'b0;
        for (int k = 4; k <= 19; k++) tick();
        chk("t6_lit1", lit_cnt, 32'd1);
        tick();
        force dut.r_lit_count = 32'hFFFFFFFE;
        #1 release dut.r_lit_count;
        for (int k = 21; k <= 34; k++) tick();
        chk("t6_preset", lit_cnt, 32'hFFFFFFFE);
        tick();
        chk("t6_reach_max", lit_cnt, 32'hFFFFFFFF);
        for (int k = 36; k <= 51; k++) tick();
        chk("t6_saturate", lit_cnt, 32'hFFFFFFFF);
        for (int k = 52; k <= 66; k++) tick();
        clr = 1'b1;
        tick();
        chk("t6_clr_max_lit",   lit_cnt,    32'h0);
        chk("t6_clr_max_pulse", 32'(pulse), 32'h1);
        clr = 1'b0;

        // 7: dark-phase firing increments the dark counter only
        light = 1'b0; lit_thr = 32'h0; dark_thr = 32'hFFFFFFFF;
        do_reset();
        for (int k = 1; k <= 40; k++) tick();
        chk("t7_dark", dark_cnt, 32'd3);
        chk("t7_lit",  lit_cnt,  32'd0);

        // 8: strict less-than compare against known LFSR values
        light = 1'b0; lit_thr = 32'h0; dark_thr = 32'h60180002; en = 1'b0;
        do_reset();
        tick();
        en = 1'b1;
        tick(); tick();
        chk("t8a_s3", 32'(pulse), 32'h0);
        tick();
        chk("t8a_s4", 32'(pulse), 32'h1);

        dark_thr = 32'h60180001; en = 1'b0;
        do_reset();
        tick();
        en = 1'b1;
        tick(); tick(); tick();
        chk("t8b_s4", 32'(pulse), 32'h0);
        tick();
        chk("t8b_s5", 32'(pulse), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
